// File: rtl/uart_prog_sender.sv
// uart_prog_sender: 8N1 loader that streams the programming header, a big-endian
// word count and a little-endian image read from a word-addressed source memory.
module uart_prog_sender #(
    parameter int          CPU_CLK          = 50_000_000,
    parameter int          BAUD_RATE        = 115200,
    parameter int          ADDR_WIDTH       = 15,
    parameter logic [71:0] PROGRAM_SEQUENCE = "ceresTEST"
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  start_i,
    input  logic [31:0]           word_count_i,
    input  logic [ADDR_WIDTH-1:0] base_addr_i,
    output logic                  mem_rd_en_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    input  logic [31:0]           mem_rdata_i,
    output logic                  tx_o,
    output logic                  busy_o,
    output logic                  done_o
);
    localparam int CLK_DIV = CPU_CLK / BAUD_RATE;
    localparam int BAUD_W  = $clog2(CLK_DIV + 1);

    typedef enum logic [2:0] {IDLE, SEND_SEQ, SEND_LEN, SEND_WORD, DONE} state_t;

    state_t                state, state_next;
    logic [31:0]           count, word_idx, hold, word_data;
    logic [ADDR_WIDTH-1:0] base, addr;
    logic [3:0]            byte_idx, bit_cnt;
    logic [BAUD_W-1:0]     baud_cnt;
    logic [7:0]            shreg, load_byte, seq_next, count_next, word_next;
    logic                  busy, baud_end, frame_end, stop_entry, last_byte;
    logic                  more_words, fetch_now, load, rd_en, fetch_q;

    assign busy       = state inside {SEND_SEQ, SEND_LEN, SEND_WORD};
    assign baud_end   = baud_cnt == BAUD_W'(CLK_DIV - 1);
    assign frame_end  = busy && baud_end && bit_cnt == 4'd9;
    assign stop_entry = busy && baud_end && bit_cnt == 4'd8;
    assign last_byte  = byte_idx == ((state == SEND_SEQ) ? 4'd8 : 4'd3);
    assign more_words = word_idx + 32'd1 != count;
    // Fetch the next word as the preceding frame enters its stop bit
    assign fetch_now  = stop_entry && byte_idx == 4'd3 &&
                        ((state == SEND_LEN && count != '0) || (state == SEND_WORD && more_words));
    assign word_data  = fetch_q ? mem_rdata_i : hold;
    assign seq_next   = 8'(PROGRAM_SEQUENCE >> {4'd7 - byte_idx, 3'b000});
    assign count_next = 8'(count >> {2'd2 - byte_idx[1:0], 3'b000});
    assign word_next  = 8'(word_data >> {byte_idx[1:0] + 2'd1, 3'b000});
    assign mem_rd_en_o = rd_en;
    assign mem_addr_o  = addr;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state <= IDLE;
        else         state <= state_next;
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        load_byte  = 8'h00;
        case (state)
            IDLE: if (start_i) begin
                state_next = SEND_SEQ;
                load       = 1'b1;
                load_byte  = PROGRAM_SEQUENCE[71:64];
            end
            SEND_SEQ: if (frame_end) begin
                load       = 1'b1;
                state_next = last_byte ? SEND_LEN : SEND_SEQ;
                load_byte  = last_byte ? count[31:24] : seq_next;
            end
            SEND_LEN: if (frame_end) begin
                if (last_byte && count == '0) state_next = DONE;
                else begin
                    load       = 1'b1;
                    state_next = last_byte ? SEND_WORD : SEND_LEN;
                    load_byte  = last_byte ? word_data[7:0] : count_next;
                end
            end
            SEND_WORD: if (frame_end) begin
                if (last_byte && !more_words) state_next = DONE;
                else begin
                    load      = 1'b1;
                    load_byte = last_byte ? word_data[7:0] : word_next;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
        tx_o   = busy ? (bit_cnt == 4'd0 ? 1'b0 : bit_cnt == 4'd9 ? 1'b1 : shreg[0]) : 1'b1;
        busy_o = busy;
        done_o = state == DONE;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count    <= '0;
            base     <= '0;
            addr     <= '0;
            word_idx <= '0;
            hold     <= '0;
            byte_idx <= '0;
            bit_cnt  <= '0;
            baud_cnt <= '0;
            shreg    <= '0;
            rd_en    <= 1'b0;
            fetch_q  <= 1'b0;
        end else begin
            rd_en   <= fetch_now;
            fetch_q <= rd_en;
            if (fetch_q) hold <= mem_rdata_i;
            if (fetch_now) addr <= (state == SEND_LEN) ? base : addr + ADDR_WIDTH'(1);
            if (state == IDLE && start_i) begin
                count    <= word_count_i;
                base     <= base_addr_i;
                word_idx <= '0;
                byte_idx <= '0;
            end
            if (load) begin
                shreg    <= load_byte;
                bit_cnt  <= '0;
                baud_cnt <= '0;
            end else if (busy) begin
                baud_cnt <= baud_end ? '0 : baud_cnt + BAUD_W'(1);
                if (baud_end) begin
                    bit_cnt <= bit_cnt + 4'd1;
                    if (bit_cnt != 4'd0) shreg <= shreg >> 1;
                end
            end
            if (frame_end) byte_idx <= last_byte ? 4'd0 : byte_idx + 4'd1;
            if (frame_end && state == SEND_WORD && last_byte) word_idx <= word_idx + 32'd1;
        end
    end
endmodule

// File: tb/tb_uart_prog_sender.sv
// tb_uart_prog_sender: checks the serial waveform, fetch pulses and handshake
// of uart_prog_sender against a byte-queue model of the programming stream.
module tb_uart_prog_sender;
    localparam int AW    = 15;
    localparam int D     = 16;
    localparam int FRAME = 10 * D;

    logic          clk = 1'b0, rst_n = 1'b0, start = 1'b0;
    logic [31:0]   word_count = '0;
    logic [AW-1:0] base_addr = '0;
    logic          mem_rd_en, tx, busy, done;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_rdata = '0;
    logic [31:0]   mem [0:(1<<AW)-1];
    int            tests = 0, fails = 0;

    always #5 clk = ~clk;
    always @(posedge clk) if (mem_rd_en) mem_rdata <= mem[mem_addr];

    uart_prog_sender #(
        .CPU_CLK(1_600_000), .BAUD_RATE(100_000), .ADDR_WIDTH(AW), .PROGRAM_SEQUENCE("ceresTEST")
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .word_count_i(word_count),
        .base_addr_i(base_addr), .mem_rd_en_o(mem_rd_en), .mem_addr_o(mem_addr),
        .mem_rdata_i(mem_rdata), .tx_o(tx), .busy_o(busy), .done_o(done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // One transfer; poke_at re-pulses start with other arguments at that cycle.
    task automatic run(input logic [31:0] n, input logic [AW-1:0] base, input int poke_at);
        byte unsigned  q[$];
        string         hdr = "ceresTEST";
        logic [31:0]   v;
        byte unsigned  cur;
        int            total, fr, b, j;
        int            tx_err = 0, busy_err = 0, rd_err = 0, addr_err = 0, rd_act = 0;
        logic          exp_tx, exp_rd;
        for (int i = 0; i < 9; i++) q.push_back(hdr[i]);
        for (int i = 3; i >= 0; i--) q.push_back(n[8*i +: 8]);
        for (int w = 0; w < int'(n); w++) begin
            v = mem[AW'(base + w)];
            for (int i = 0; i < 4; i++) q.push_back(v[8*i +: 8]);
        end
        total = q.size() * FRAME;
        @(negedge clk);
        start = 1'b1; word_count = n; base_addr = base;
        for (int k = 1; k <= total + 2; k++) begin
            @(negedge clk);
            start = (k == poke_at);
            if (k == poke_at) begin word_count = n + 7; base_addr = base + 3; end
            if (k <= total) begin
                fr  = (k - 1) / FRAME;
                b   = ((k - 1) % FRAME) / D;
                cur = q[fr];
                exp_tx = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : cur[b-1];
                j = (fr - 12) / 4;
                exp_rd = fr >= 12 && (fr - 12) % 4 == 0 && j < int'(n) && b == 9 && (k - 1) % D == 0;
                if (tx !== exp_tx) tx_err++;
                if (busy !== 1'b1 || done !== 1'b0) busy_err++;
                if (mem_rd_en !== exp_rd) rd_err++;
                if (mem_rd_en === 1'b1) rd_act++;
                if (exp_rd && mem_addr !== AW'(base + j)) addr_err++;
            end else if (k == total + 1) begin
                check("done_pulse", {29'd0, done, busy, tx}, 32'b101);
            end else begin
                check("after_done", {29'd0, done, busy, tx}, 32'b001);
            end
        end
        check("tx_stream", tx_err, 0);
        check("busy_window", busy_err, 0);
        check("rd_timing", rd_err, 0);
        check("rd_addr", addr_err, 0);
        check("rd_count", rd_act, n);
        if (n != 0) check("addr_hold", mem_addr, AW'(base + n - 1));
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = $urandom;
        mem[16] = 32'hDEADBEEF;
        mem[17] = 32'h01020304;
        repeat (3) @(negedge clk);
        check("reset_out", {27'd0, tx, busy, done, mem_rd_en, 1'b0}, 32'b10000);
        check("reset_addr", mem_addr, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        run(0, AW'($urandom), 0);
        run(2, 15'h0010, 0);
        run(2, 15'h7FFF, 0);
        run(3, AW'($urandom), 700);
        run(1, AW'($urandom), (13 + 4) * FRAME + 1);
        for (int r = 0; r < 3; r++) run($urandom_range(0, 4), AW'($urandom), 0);
        @(negedge clk);
        start = 1'b1; word_count = 1; base_addr = AW'($urandom);
        for (int k = 1; k <= 4 * FRAME + 3; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        check("abort_pre_tx", tx, 0);
        check("abort_pre_busy", busy, 1);
        #1 rst_n = 1'b0;
        #1;
        check("abort_tx", tx, 1);
        check("abort_busy", busy, 0);
        repeat (3) begin
            @(negedge clk);
            check("abort_no_done", {30'd0, done, mem_rd_en}, 0);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("abort_idle", {29'd0, tx, busy, done}, 32'b100);
        run(2, AW'($urandom), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
